// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter that shares one serial EEPROM read/write engine and enforces a post-write recovery gap.
// Define EE_TIMEOUT_EN to add the WAIT watchdog and the ERR output.
module eeprom_arbiter #(
    parameter int NREQ        = 4,
    parameter int WR_GAP_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     REQ_WE,
    input  logic [NREQ*11-1:0]  REQ_ADDR,
    input  logic [NREQ*8-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     DONE,
    output logic [7:0]          RDATA,
    output logic                BUSY,
    output logic                EE_WR,
    output logic                EE_RD,
    output logic [10:0]         EE_ADDR,
    inout  wire  [7:0]          EE_DATA,
`ifdef EE_TIMEOUT_EN
    output logic                ERR,
`endif
    input  logic                EE_ACK
);

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMPL  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_drive;
    logic [15:0]   r_gap;
    logic [IW:0]   w_pick;
    logic          w_found;
    logic [IW-1:0] w_win;
    logic          w_tmo;

    // Search upward from ptr+1 so the last winner is considered last; MSB of the result flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!res[IW] && req[j]) begin
                res = {1'b1, IW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_pick  = rr_pick(REQ, r_ptr);
    assign w_found = w_pick[IW];
    assign w_win   = w_pick[IW-1:0];

    assign EE_DATA = r_drive ? r_wdata : 8'hzz;

`ifdef EE_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_tmo = (r_wdog == 16'(TIMEOUT_CYC - 1));

    // Watchdog runs only in WAIT; ERR rides along with DONE in CMPL.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wdog <= 16'd0;
            ERR    <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_wdog <= 16'd0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + 16'd1;
                if (!EE_ACK && w_tmo) begin
                    ERR <= 1'b1;
                end
            end
        end
    end
`else
    // Without the watchdog WAIT never aborts; the limit parameter is inert.
    assign w_tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    // Next-state decode.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_nxt = S_ISSUE;
                else         w_nxt = S_IDLE;
            end
            S_ISSUE: w_nxt = S_WAIT;
            S_WAIT: begin
                if (EE_ACK || w_tmo) w_nxt = S_CMPL;
                else                 w_nxt = S_WAIT;
            end
            S_CMPL: begin
                if (r_we && (WR_GAP_CYC > 0)) w_nxt = S_GAP;
                else                          w_nxt = S_IDLE;
            end
            S_GAP: begin
                if (r_gap == 16'd0) w_nxt = S_IDLE;
                else                w_nxt = S_GAP;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // State, command latch and all registered outputs; strobes and DONE default low each cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_ptr   <= IW'(NREQ - 1);
            r_owner <= '0;
            r_we    <= 1'b0;
            r_wdata <= 8'h00;
            r_drive <= 1'b0;
            r_gap   <= 16'd0;
            GNT     <= '0;
            DONE    <= '0;
            RDATA   <= 8'h00;
            BUSY    <= 1'b0;
            EE_WR   <= 1'b0;
            EE_RD   <= 1'b0;
            EE_ADDR <= 11'h000;
        end else begin
            r_state <= w_nxt;
            BUSY    <= (w_nxt != S_IDLE);
            DONE    <= '0;
            EE_WR   <= 1'b0;
            EE_RD   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_we    <= REQ_WE[w_win];
                        r_wdata <= REQ_WDATA[int'(w_win)*DW +: DW];
                        r_drive <= REQ_WE[w_win];
                        EE_ADDR <= REQ_ADDR[int'(w_win)*AW +: AW];
                        EE_WR   <= REQ_WE[w_win];
                        EE_RD   <= !REQ_WE[w_win];
                        GNT     <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    end
                end
                S_WAIT: begin
                    if (EE_ACK) begin
                        DONE[r_owner] <= 1'b1;
                        if (!r_we) RDATA <= EE_DATA;
                    end else if (w_tmo) begin
                        DONE[r_owner] <= 1'b1;
                    end
                end
                S_CMPL: begin
                    GNT     <= '0;
                    r_drive <= 1'b0;
                    r_gap   <= 16'(WR_GAP_CYC - 1);
                end
                S_GAP: begin
                    if (r_gap != 16'd0) r_gap <= r_gap - 16'd1;
                end
                default: begin
                    GNT <= GNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Scoreboard bench for eeprom_arbiter: a monitor logs strobe and DONE events that each scenario task compares.
module tb_eeprom_arbiter;

    typedef struct {
        int          idx;
        bit          wr;
        bit          rd;
        logic [10:0] addr;
        logic [7:0]  data;
        logic [7:0]  rdat;
        int          cyc;
        bit          err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req_we;
    logic [43:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata;
    logic        busy, ee_wr, ee_rd;
    logic [10:0] ee_addr;
    wire  [7:0]  ee_data;
    logic        ee_ack;
`ifdef EE_TIMEOUT_EN
    logic        err;
`endif

    logic        eng_en = 1'b0, eng_ack = 1'b0, eng_drv = 1'b0, man_ack = 1'b0, probe_drv = 1'b0;
    logic [7:0]  eng_val = 8'h00, eng_rdata = 8'h00, probe_val = 8'h00;
    int          eng_lat = 2;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    txn_t        exp_q[$];
    txn_t        iss_q[$];
    txn_t        done_q[$];

    assign ee_ack  = eng_ack | man_ack;
    assign ee_data = eng_drv ? eng_val : (probe_drv ? probe_val : 8'hzz);

    always #5 clk = ~clk;

    eeprom_arbiter #(.NREQ(4), .WR_GAP_CYC(16), .TIMEOUT_CYC(32)) dut (
        .CLK(clk), .RESET(rst_n), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .GNT(gnt), .DONE(done), .RDATA(rdata), .BUSY(busy),
        .EE_WR(ee_wr), .EE_RD(ee_rd), .EE_ADDR(ee_addr), .EE_DATA(ee_data),
`ifdef EE_TIMEOUT_EN
        .ERR(err),
`endif
        .EE_ACK(ee_ack)
    );

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    // Monitor: log every strobe cycle and every DONE cycle.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            cyc++;
            t.idx = oh_idx(gnt); t.wr = ee_wr; t.rd = ee_rd; t.addr = ee_addr;
            t.data = ee_data; t.rdat = rdata; t.cyc = cyc; t.err = 1'b0;
            if (ee_wr || ee_rd) iss_q.push_back(t);
            if (|done) begin
                t.idx = oh_idx(done);
`ifdef EE_TIMEOUT_EN
                t.err = err;
`endif
                done_q.push_back(t);
            end
        end
    end

    // Engine model: ACK eng_lat cycles after a strobe, with read data alongside.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_en && (ee_wr || ee_rd)) begin
                bit rd;
                rd = ee_rd;
                repeat (eng_lat) @(negedge clk);
                eng_ack = 1'b1;
                if (rd) begin eng_drv = 1'b1; eng_val = eng_rdata; end
                @(negedge clk);
                eng_ack = 1'b0;
                eng_drv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input bit we, input logic [10:0] a, input logic [7:0] d);
        txn_t e;
        e.idx = i; e.wr = we; e.rd = !we; e.addr = a; e.data = d; e.rdat = 8'h00; e.cyc = 0; e.err = 1'b0;
        exp_q.push_back(e);
        req_we[i] = we;
        req_addr[i*11 +: 11] = a;
        req_wdata[i*8 +: 8] = d;
        req[i] = 1'b1;
    endtask

    task automatic flush();
        int t = 0;
        req = '0;
        tick();
        while ((busy || gnt != 4'b0000) && t < 300) begin tick(); t++; end
        n_checks++;
        if (busy) begin n_errors++; $display("FAIL flush_idle busy=%b want 0", busy); end
        tick();
        iss_q.delete(); done_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) tick();
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_checks++; if (done !== 4'b0000) begin n_errors++; $display("FAIL rst_done got %b want 0000", done); end
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL rst_rdata got %h want 00", rdata); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if ({ee_wr, ee_rd} !== 2'b00) begin n_errors++; $display("FAIL rst_strobes got %b want 00", {ee_wr, ee_rd}); end
        n_checks++; if (ee_addr !== 11'h000) begin n_errors++; $display("FAIL rst_addr got %h want 000", ee_addr); end
        probe_drv = 1'b1; probe_val = 8'hC3; #1;
        n_checks++; if (ee_data !== 8'hC3) begin n_errors++; $display("FAIL rst_data_release got %h want c3", ee_data); end
        probe_drv = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        txn_t e, o;
        int   t = 0;
        eng_en = 1'b1; eng_lat = 2;
        set_req(0, 1'b1, 11'h1A5, 8'h3C);
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL wr_gnt_next got %b want 0001", gnt); end
        n_checks++; if (ee_wr !== 1'b1 || ee_addr !== 11'h1A5) begin n_errors++; $display("FAIL wr_issue got wr=%b addr=%h want wr=1 addr=1a5", ee_wr, ee_addr); end
        // Fields change after grant and must not reach the engine.
        req[0] = 1'b0; req_we[0] = 1'b0; req_addr[10:0] = 11'h000; req_wdata[7:0] = 8'hFF;
        while (done_q.size() < 1 && t < 100) begin tick(); t++; end
        n_checks++; if (done_q.size() != 1) begin n_errors++; $display("FAIL wr_done_count got %0d want 1", done_q.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                probe_drv = 1'b1; probe_val = 8'h5A; #1;
                n_checks++; if (ee_data !== 8'h5A) begin n_errors++; $display("FAIL wr_release got %h want 5a", ee_data); end
                probe_drv = 1'b0;
            end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL wr_gap_busy k=%0d got %b want 1", k, busy); end
            tick();
        end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wr_gap_end got %b want 0", busy); end
        n_checks++; if (iss_q.size() != 1) begin n_errors++; $display("FAIL wr_issue_count got %0d want 1", iss_q.size()); end
        if (iss_q.size() > 0 && done_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = iss_q.pop_front();
            n_checks++;
            if (o.idx != e.idx || o.wr != e.wr || o.rd != e.rd || o.addr !== e.addr || o.data !== e.data) begin
                n_errors++; $display("FAIL wr_cmd got i%0d w%0d r%0d a%h d%h want i%0d w%0d r%0d a%h d%h",
                    o.idx, o.wr, o.rd, o.addr, o.data, e.idx, e.wr, e.rd, e.addr, e.data);
            end
            o = done_q.pop_front();
            n_checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                n_errors++; $display("FAIL wr_done got i%0d d%h want i%0d d%h", o.idx, o.data, e.idx, e.data);
            end
        end
        flush();
    endtask

    task automatic test_single_read();
        txn_t e, o;
        int   t = 0;
        eng_rdata = 8'hA7;
        set_req(2, 1'b0, 11'h7FF, 8'h00);
        while (done_q.size() < 1 && t < 100) begin tick(); if (iss_q.size() >= 1) req[2] = 1'b0; t++; end
        n_checks++; if (done_q.size() != 1) begin n_errors++; $display("FAIL rd_done_count got %0d want 1", done_q.size()); end
        n_checks++; if (iss_q.size() != 1) begin n_errors++; $display("FAIL rd_issue_count got %0d want 1", iss_q.size()); end
        if (iss_q.size() > 0 && done_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = iss_q.pop_front();
            n_checks++;
            if (o.idx != e.idx || o.wr != e.wr || o.rd != e.rd || o.addr !== e.addr) begin
                n_errors++; $display("FAIL rd_cmd got i%0d w%0d r%0d a%h want i%0d w%0d r%0d a%h",
                    o.idx, o.wr, o.rd, o.addr, e.idx, e.wr, e.rd, e.addr);
            end
            o = done_q.pop_front();
            n_checks++;
            if (o.idx != 2 || o.rdat !== 8'hA7) begin n_errors++; $display("FAIL rd_done got i%0d rdata %h want i2 a7", o.idx, o.rdat); end
        end
        repeat (5) tick();
        n_checks++; if (rdata !== 8'hA7) begin n_errors++; $display("FAIL rd_hold got %h want a7", rdata); end
        flush();
    endtask

    task automatic test_write_gap();
        int t = 0;
        eng_rdata = 8'h5C;
        set_req(1, 1'b1, 11'h2B4, 8'h96);
        while (done_q.size() < 2 && t < 300) begin
            tick(); t++;
            if (iss_q.size() == 1 && req[1]) begin req[1] = 1'b0; set_req(3, 1'b0, 11'h055, 8'h00); end
            if (iss_q.size() >= 2) req[3] = 1'b0;
        end
        n_checks++; if (done_q.size() != 2 || iss_q.size() != 2) begin n_errors++; $display("FAIL gap_counts got done=%0d iss=%0d want 2 2", done_q.size(), iss_q.size()); end
        if (done_q.size() == 2 && iss_q.size() == 2 && exp_q.size() == 2) begin
            n_checks++;
            if (iss_q[0].idx != 1 || iss_q[0].wr != 1'b1 || iss_q[0].addr !== exp_q[0].addr || iss_q[0].data !== exp_q[0].data) begin
                n_errors++; $display("FAIL gap_wr_cmd got i%0d w%0d a%h d%h want i1 w1 a%h d%h",
                    iss_q[0].idx, iss_q[0].wr, iss_q[0].addr, iss_q[0].data, exp_q[0].addr, exp_q[0].data);
            end
            n_checks++; if (done_q[0].idx != 1 || done_q[0].rdat !== 8'hA7) begin n_errors++; $display("FAIL gap_wr_done got i%0d rdata %h want i1 a7", done_q[0].idx, done_q[0].rdat); end
            n_checks++; if (iss_q[1].idx != 3 || iss_q[1].rd != 1'b1) begin n_errors++; $display("FAIL gap_rd_cmd got i%0d r%0d want i3 r1", iss_q[1].idx, iss_q[1].rd); end
            // CMPL, 16 GAP cycles, one IDLE sample, then the grant cycle.
            n_checks++; if (iss_q[1].cyc - done_q[0].cyc != 18) begin n_errors++; $display("FAIL gap_spacing got %0d want 18", iss_q[1].cyc - done_q[0].cyc); end
            n_checks++; if (done_q[1].idx != 3 || done_q[1].rdat !== 8'h5C) begin n_errors++; $display("FAIL gap_rd_done got i%0d rdata %h want i3 5c", done_q[1].idx, done_q[1].rdat); end
        end
        flush();
    endtask

    task automatic test_round_robin();
        int t = 0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        eng_rdata = 8'h11; req_we = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            txn_t e;
            e.idx = k % 4; e.wr = 1'b0; e.rd = 1'b1; e.addr = 11'h000; e.data = 8'h00; e.rdat = 8'h00; e.cyc = 0; e.err = 1'b0;
            exp_q.push_back(e);
        end
        req = 4'b1111;
        while (iss_q.size() < 5 && t < 400) begin tick(); t++; end
        req = 4'b0000;
        n_checks++; if (iss_q.size() < 5) begin n_errors++; $display("FAIL rr_count got %0d want 5", iss_q.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < iss_q.size()) begin
                n_checks++;
                if (iss_q[k].idx != exp_q[k].idx) begin n_errors++; $display("FAIL rr_order slot %0d got %0d want %0d", k, iss_q[k].idx, exp_q[k].idx); end
            end
        end
        flush();
    endtask

    task automatic test_reset_mid_wait();
        int t = 0;
        eng_en = 1'b0;
        set_req(1, 1'b1, 11'h3FF, 8'hE1);
        while (iss_q.size() < 1 && t < 50) begin tick(); t++; end
        req[1] = 1'b0;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0010) begin n_errors++; $display("FAIL mid_wait_pre got busy=%b gnt=%b want 1 0010", busy, gnt); end
        rst_n = 1'b0; #1;
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst got gnt=%b busy=%b want 0000 0", gnt, busy); end
        probe_drv = 1'b1; probe_val = 8'h5A; #1;
        n_checks++; if (ee_data !== 8'h5A) begin n_errors++; $display("FAIL mid_rst_release got %h want 5a", ee_data); end
        probe_drv = 1'b0;
        tick();
        rst_n = 1'b1; eng_en = 1'b1;
        iss_q.delete(); done_q.delete(); exp_q.delete();
        set_req(3, 1'b0, 11'h010, 8'h00);
        set_req(0, 1'b0, 11'h020, 8'h00);
        t = 0;
        while (iss_q.size() < 1 && t < 50) begin tick(); t++; end
        req = 4'b0000;
        n_checks++;
        if (iss_q.size() < 1) begin n_errors++; $display("FAIL post_rst_grant got none want 0"); end
        else if (iss_q[0].idx != 0) begin n_errors++; $display("FAIL post_rst_grant got %0d want 0", iss_q[0].idx); end
        flush();
    endtask

    task automatic test_ack_outside_wait();
        man_ack = 1'b1; tick(); man_ack = 1'b0; tick();
        n_checks++; if (done_q.size() != 0 || busy !== 1'b0) begin n_errors++; $display("FAIL idle_ack got dones=%0d busy=%b want 0 0", done_q.size(), busy); end
        eng_en = 1'b0;
        set_req(2, 1'b1, 11'h123, 8'h44);
        tick();
        req[2] = 1'b0; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (3) tick();
        n_checks++; if (done_q.size() != 0 || busy !== 1'b1) begin n_errors++; $display("FAIL issue_ack got dones=%0d busy=%b want 0 1", done_q.size(), busy); end
        man_ack = 1'b1; tick(); man_ack = 1'b0; repeat (2) tick();
        n_checks++; if (done_q.size() != 1) begin n_errors++; $display("FAIL wait_ack got dones=%0d want 1", done_q.size()); end
        eng_en = 1'b1;
        flush();
    endtask

`ifdef EE_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] rd_before;
        int         t = 0;
        eng_en = 1'b0;
        rd_before = rdata;
        set_req(0, 1'b0, 11'h0F0, 8'h00);
        while (done_q.size() < 1 && t < 200) begin tick(); if (iss_q.size() >= 1) req[0] = 1'b0; t++; end
        n_checks++; if (done_q.size() != 1 || iss_q.size() != 1) begin n_errors++; $display("FAIL tmo_counts got done=%0d iss=%0d want 1 1", done_q.size(), iss_q.size()); end
        if (done_q.size() == 1 && iss_q.size() == 1) begin
            n_checks++; if (done_q[0].cyc - iss_q[0].cyc != 33) begin n_errors++; $display("FAIL tmo_delay got %0d want 33", done_q[0].cyc - iss_q[0].cyc); end
            n_checks++; if (done_q[0].err != 1'b1 || done_q[0].idx != 0) begin n_errors++; $display("FAIL tmo_err got err=%0d i%0d want 1 i0", done_q[0].err, done_q[0].idx); end
        end
        n_checks++; if (rdata !== rd_before) begin n_errors++; $display("FAIL tmo_rdata got %h want %h", rdata, rd_before); end
        eng_en = 1'b1;
        flush();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_write_gap();
        test_round_robin();
        test_reset_mid_wait();
        test_ack_outside_wait();
`ifdef EE_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one serial EEPROM read/write engine among NREQ requesters.
- Accepts per-requester read/write commands and sequences the engine's WR/RD/ADDR/DATA/ACK handshake.
- Returns read data and a completion pulse to the owning requester.
- Enforces a post-write recovery gap so that the EEPROM's internal write cycle can complete.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WR_GAP_CYC, 16, idle CLK cycles enforced after a write completes before the next grant (0 = no gap).
- TIMEOUT_CYC, 4096, CLK cycles allowed in WAIT before abort (used only with EE_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester request level.
- REQ_WE  in  NREQ  1 = write, 0 = read.
- REQ_ADDR  in  NREQ*11  11-bit EEPROM address; requester i uses bits [11i+10:11i].
- REQ_WDATA  in  NREQ*8  write data; requester i uses bits [8i+7:8i].
- GNT  out  NREQ  one-hot ownership level.
- DONE  out  NREQ  one-cycle completion pulse to the owner.
- RDATA  out  8  last read byte.
- BUSY  out  1  high in any state other than IDLE.
- EE_WR  out  1  write strobe to the engine.
- EE_RD  out  1  read strobe to the engine.
- EE_ADDR  out  11  address to the engine.
- EE_DATA  inout  8  engine parallel data bus.
- EE_ACK  in  1  engine end-of-operation pulse.

Behaviour:
- Reset values: GNT=0, DONE=0, RDATA=8'h00, BUSY=0, EE_WR=0, EE_RD=0, EE_ADDR=0, EE_DATA=Z, state=IDLE, round-robin pointer=NREQ-1, gap counter=0.
- States: IDLE, ISSUE, WAIT, CMPL, GAP.
- IDLE:
  - If any REQ bit is set, the winner is the first set bit searching upward from pointer+1 (modulo NREQ).
  - Register the winner's index, WE, ADDR and WDATA; set GNT[winner]=1; pointer<=winner; go to ISSUE.
  - Result: GNT is high 1 cycle after REQ is sampled.
- ISSUE (exactly 1 cycle):
  - EE_WR=WE or EE_RD=~WE, never both.
  - EE_ADDR=latched address.
  - Go to WAIT.
- WAIT:
  - EE_WR=EE_RD=0; EE_ADDR held.
  - For a write, EE_DATA is driven with the latched WDATA from ISSUE through CMPL inclusive. For a read, EE_DATA=Z throughout.
  - On EE_ACK=1: for a read, RDATA<=EE_DATA sampled in that cycle. Then go to CMPL.
- CMPL (1 cycle):
  - DONE[owner]=1 and GNT<=0 in the same cycle.
  - Next state is GAP if WE and WR_GAP_CYC>0 (counter loaded with WR_GAP_CYC-1); otherwise IDLE.
- GAP:
  - Counter decrements each cycle; exit to IDLE when it reads 0.
  - No grant is issued. BUSY stays high.
- Command latching:
  - Command fields are latched at grant. Later changes to REQ_ADDR/REQ_WDATA/REQ_WE are ignored until the next grant.
- REQ deassertion:
  - Deasserted before grant: the request is withdrawn with no side effect.
  - Deasserted after grant: the operation still completes and DONE still pulses.
- Back-to-back requests: a requester holding REQ through its DONE is eligible again only after every other active requester has been served once (fairness).
- EE_ACK outside WAIT is ignored.
- RDATA holds its value until the next read completes; writes do not alter it.
- Asserting RESET mid-operation aborts immediately to reset values. The engine shares the same reset.

Optional Feature:
- Macro EE_TIMEOUT_EN.
- Defined:
  - Adds output ERR (1 bit, reset 0) and a 16-bit watchdog counter, cleared on entry to WAIT.
  - If TIMEOUT_CYC cycles elapse in WAIT without EE_ACK: ERR pulses 1 cycle together with DONE[owner] in CMPL, and RDATA is unchanged.
  - The GAP state is still applied if the aborted operation was a write.
- Undefined: no ERR port and no counter; WAIT waits indefinitely.

Test Plan:
- Single write: REQ[0]=1, WE=1, ADDR=11'h1A5, WDATA=8'h3C → GNT[0] next cycle; EE_WR single-cycle with EE_ADDR=11'h1A5; EE_DATA=8'h3C until CMPL; after ACK, DONE[0] pulses once; BUSY held for the 16-cycle gap.
- Single read: REQ[2]=1, WE=0, ADDR=11'h7FF; engine model drives 8'hA7 with ACK → EE_RD single cycle; EE_DATA=Z from the arbiter; RDATA=8'hA7 in the DONE[2] cycle and held afterwards.
- Round-robin: REQ=4'b1111 held, all reads → grant order 0,1,2,3,0 from reset; no requester is granted twice in a row.
- Write gap: requester 1 writes while requester 3 waits → GNT[3] rises no earlier than 16 cycles after DONE[1].
- Reset mid-WAIT: assert RESET while in WAIT → same-cycle GNT=0, EE_DATA=Z, BUSY=0; the first request after release goes to requester 0.
- EE_TIMEOUT_EN build with TIMEOUT_CYC=32 and no ACK → ERR and DONE pulse 32 cycles after entering WAIT; RDATA unchanged.
